// File: rtl/latrnq_bist_if.sv
// Handshake and latch-drive bundle for the latrnq_bist self-test driver.
// FIRST_FAIL_IDX exists only when LATRNQ_BIST_FAIL_LOG_EN is defined.
interface latrnq_bist_if #(
    parameter int unsigned CNT_W = 8
);
    logic             start;
    logic             lat_q;
    logic             lat_d;
    logic             lat_e;
    logic             lat_rn;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] fail_cnt;
`ifdef LATRNQ_BIST_FAIL_LOG_EN
    logic [15:0]      first_fail_idx;

    modport master (
        output start, lat_q,
        input  lat_d, lat_e, lat_rn, busy, done, pass, fail_cnt, first_fail_idx
    );
    modport slave (
        input  start, lat_q,
        output lat_d, lat_e, lat_rn, busy, done, pass, fail_cnt, first_fail_idx
    );
`else
    modport master (
        output start, lat_q,
        input  lat_d, lat_e, lat_rn, busy, done, pass, fail_cnt
    );
    modport slave (
        input  start, lat_q,
        output lat_d, lat_e, lat_rn, busy, done, pass, fail_cnt
    );
`endif
endinterface

// File: rtl/latrnq_bist.sv
// BIST driver for active-low-reset D latches: LFSR-driven D/E/RN phases, golden Q model,
// saturating mismatch count. LATRNQ_BIST_FAIL_LOG_EN adds the first-fail index capture.
module latrnq_bist #(
    parameter int unsigned N_PAT  = 16,
    parameter int unsigned SETTLE = 2,
    parameter logic [7:0]  SEED   = 8'hA5,
    parameter int unsigned CNT_W  = 8
) (
    input logic          clk,
    input logic          rn,
    latrnq_bist_if.slave bus
);
    localparam logic [7:0]  SEED_EFF    = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam int unsigned PH_W        = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(SETTLE - 1);
    localparam logic [15:0] LAST_IDX    = 16'(N_PAT - 1);

    typedef enum logic [2:0] {
        StIdle, StInit, StApply, StOpen, StClose, StDisturb, StFin
    } state_e;

    state_e           state_q;
    logic [PH_W-1:0]  ph_q;
    logic [7:0]       lfsr_q;
    logic [15:0]      idx_q;
    logic             exp_q;
    logic             lat_d_q;
    logic             lat_e_q;
    logic             lat_rn_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic [CNT_W-1:0] fail_cnt_q;

    logic             pat_d, pat_e, pat_r, pat_x;
    logic             exp_new;
    logic             mismatch;
    logic             ph_last;
    logic [7:0]       lfsr_nxt;
    logic [CNT_W-1:0] fail_cnt_upd;

    always_comb begin
        pat_d        = lfsr_q[0];
        pat_e        = lfsr_q[1];
        pat_r        = lfsr_q[2];
        pat_x        = lfsr_q[3];
        // Reset dominates enable in the golden model
        exp_new      = pat_r ? 1'b0 : (pat_e ? pat_d : exp_q);
        mismatch     = (bus.lat_q != exp_new);
        ph_last      = (ph_q == PH_LAST);
        lfsr_nxt     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        fail_cnt_upd = fail_cnt_q;
        if (mismatch && (fail_cnt_q != '1)) begin
            fail_cnt_upd = fail_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rn) begin
        if (!rn) begin
            state_q    <= StIdle;
            ph_q       <= '0;
            lfsr_q     <= SEED_EFF;
            idx_q      <= '0;
            exp_q      <= 1'b0;
            lat_d_q    <= 1'b0;
            lat_e_q    <= 1'b0;
            lat_rn_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_cnt_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    lat_rn_q <= 1'b1;
                    lat_e_q  <= 1'b0;
                    if (bus.start) begin
                        state_q    <= StInit;
                        ph_q       <= '0;
                        fail_cnt_q <= '0;
                        lfsr_q     <= SEED_EFF;
                        idx_q      <= '0;
                        exp_q      <= 1'b0;
                        busy_q     <= 1'b1;
                        pass_q     <= 1'b0;
                        lat_rn_q   <= 1'b0;
                    end
                end
                StInit: begin
                    ph_q <= ph_last ? '0 : ph_q + PH_W'(1);
                    if (ph_last) begin
                        state_q  <= StApply;
                        lat_d_q  <= pat_d;
                        lat_rn_q <= ~pat_r;
                    end
                end
                StApply: begin
                    ph_q <= ph_last ? '0 : ph_q + PH_W'(1);
                    if (ph_last) begin
                        state_q <= StOpen;
                        lat_e_q <= pat_e;
                    end
                end
                StOpen: begin
                    ph_q <= ph_last ? '0 : ph_q + PH_W'(1);
                    if (ph_last) begin
                        state_q  <= StClose;
                        lat_e_q  <= 1'b0;
                        lat_rn_q <= 1'b1;
                    end
                end
                StClose: begin
                    ph_q <= ph_last ? '0 : ph_q + PH_W'(1);
                    if (ph_last) begin
                        state_q <= StDisturb;
                        lat_d_q <= pat_d ^ pat_x;
                    end
                end
                StDisturb: begin
                    ph_q <= ph_last ? '0 : ph_q + PH_W'(1);
                    if (ph_last) begin
                        fail_cnt_q <= fail_cnt_upd;
                        exp_q      <= exp_new;
                        lfsr_q     <= lfsr_nxt;
                        idx_q      <= idx_q + 16'd1;
                        if (idx_q == LAST_IDX) begin
                            state_q  <= StFin;
                            done_q   <= 1'b1;
                            busy_q   <= 1'b0;
                            pass_q   <= (fail_cnt_upd == '0);
                            lat_e_q  <= 1'b0;
                            lat_rn_q <= 1'b1;
                        end else begin
                            // Next pattern is driven straight from the advanced LFSR
                            state_q  <= StApply;
                            lat_d_q  <= lfsr_nxt[0];
                            lat_rn_q <= ~lfsr_nxt[2];
                            lat_e_q  <= 1'b0;
                        end
                    end
                end
                StFin: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

`ifdef LATRNQ_BIST_FAIL_LOG_EN
    logic [15:0] first_fail_idx_q;

    // An all-zero count at the compare means no earlier mismatch in this run
    always_ff @(posedge clk or negedge rn) begin
        if (!rn) begin
            first_fail_idx_q <= '0;
        end else if ((state_q == StIdle) && bus.start) begin
            first_fail_idx_q <= '0;
        end else if ((state_q == StDisturb) && ph_last && mismatch && (fail_cnt_q == '0)) begin
            first_fail_idx_q <= idx_q;
        end
    end

    assign bus.first_fail_idx = first_fail_idx_q;
`endif

    assign bus.lat_d    = lat_d_q;
    assign bus.lat_e    = lat_e_q;
    assign bus.lat_rn   = lat_rn_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.pass     = pass_q;
    assign bus.fail_cnt = fail_cnt_q;

endmodule

// File: tb/tb_latrnq_bist.sv
// Directed bench for latrnq_bist: table of full runs against latch models plus hand sequences
// for reset, mid-run reset, START while busy and START around FIN.
module tb_latrnq_bist;
    logic clk = 1'b0;
    logic rn  = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   mode0    = 0;   // dut0 Q model: 0 ideal, 1 stuck-0, 2 stuck-1, 3 Q=D
    logic q0_ideal = 1'b0;

    logic        start_r [4];
    logic        busy_w  [4];
    logic        done_w  [4];
    logic        pass_w  [4];
    logic [31:0] cnt_w   [4];
    logic [31:0] ffi_w   [4];

    latrnq_bist_if #(.CNT_W(8)) if0 ();
    latrnq_bist_if #(.CNT_W(8)) if1 ();
    latrnq_bist_if #(.CNT_W(2)) if2 ();
    latrnq_bist_if #(.CNT_W(8)) if3 ();

    latrnq_bist #(.N_PAT(16), .SETTLE(2), .SEED(8'hA5), .CNT_W(8))
        u_dut0 (.clk(clk), .rn(rn), .bus(if0));
    latrnq_bist #(.N_PAT(1), .SETTLE(2), .SEED(8'hA5), .CNT_W(8))
        u_dut1 (.clk(clk), .rn(rn), .bus(if1));
    latrnq_bist #(.N_PAT(255), .SETTLE(2), .SEED(8'hA5), .CNT_W(2))
        u_dut2 (.clk(clk), .rn(rn), .bus(if2));
    latrnq_bist #(.N_PAT(16), .SETTLE(2), .SEED(8'h00), .CNT_W(8))
        u_dut3 (.clk(clk), .rn(rn), .bus(if3));

    always #5 clk = ~clk;

    always @(if0.lat_rn or if0.lat_e or if0.lat_d) begin
        if (!if0.lat_rn) q0_ideal = 1'b0;
        else if (if0.lat_e) q0_ideal = if0.lat_d;
    end

    assign if0.lat_q = (mode0 == 1) ? 1'b0 : (mode0 == 2) ? 1'b1 :
                       (mode0 == 3) ? if0.lat_d : q0_ideal;
    assign if1.lat_q = 1'b1;
    assign if2.lat_q = if2.lat_d;
    assign if3.lat_q = if3.lat_d;

    assign if0.start = start_r[0];
    assign if1.start = start_r[1];
    assign if2.start = start_r[2];
    assign if3.start = start_r[3];

    assign {busy_w[0], done_w[0], pass_w[0]} = {if0.busy, if0.done, if0.pass};
    assign {busy_w[1], done_w[1], pass_w[1]} = {if1.busy, if1.done, if1.pass};
    assign {busy_w[2], done_w[2], pass_w[2]} = {if2.busy, if2.done, if2.pass};
    assign {busy_w[3], done_w[3], pass_w[3]} = {if3.busy, if3.done, if3.pass};
    assign cnt_w[0] = 32'(if0.fail_cnt);
    assign cnt_w[1] = 32'(if1.fail_cnt);
    assign cnt_w[2] = 32'(if2.fail_cnt);
    assign cnt_w[3] = 32'(if3.fail_cnt);
`ifdef LATRNQ_BIST_FAIL_LOG_EN
    assign ffi_w[0] = 32'(if0.first_fail_idx);
    assign ffi_w[1] = 32'(if1.first_fail_idx);
    assign ffi_w[2] = 32'(if2.first_fail_idx);
    assign ffi_w[3] = 32'(if3.first_fail_idx);
`else
    assign ffi_w[0] = '0;
    assign ffi_w[1] = '0;
    assign ffi_w[2] = '0;
    assign ffi_w[3] = '0;
`endif

    typedef struct {
        int         which;
        int         mode;
        logic [7:0] seed;
        int         npat;
        int         cntw;
        int         exp_lat;
        int         hand_cnt;  // -1: take count from the reference model
    } run_vec_t;

    run_vec_t runs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void ref_run(input logic [7:0] seed, input int npat, input int mode,
                                    output int cnt, output int first);
        logic [7:0] l;
        logic ex, en, q, d, e, r, x;
        l     = (seed == 8'h00) ? 8'h01 : seed;
        ex    = 1'b0;
        cnt   = 0;
        first = -1;
        for (int i = 0; i < npat; i++) begin
            d  = l[0];
            e  = l[1];
            r  = l[2];
            x  = l[3];
            en = r ? 1'b0 : (e ? d : ex);
            case (mode)
                0:       q = en;
                1:       q = 1'b0;
                2:       q = 1'b1;
                default: q = d ^ x;
            endcase
            if (q != en) begin
                if (first < 0) first = i;
                cnt++;
            end
            ex = en;
            l  = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
        end
    endfunction

    // Pulse START for one edge (edge k) and count edges until DONE; -1 if budget expires
    task automatic do_run(input int which, input int budget, output int lat);
        lat = -1;
        @(negedge clk);
        start_r[which] = 1'b1;
        @(posedge clk);
        #1;
        start_r[which] = 1'b0;
        check($sformatf("dut%0d_busy_after_start", which), 32'(busy_w[which]), 32'd1);
        for (int c = 1; c <= budget; c++) begin
            @(posedge clk);
            #1;
            if (done_w[which]) begin
                lat = c;
                break;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat, cnt, first, exp_cnt, exp_first, cmax, done_seen;

        for (int i = 0; i < 4; i++) start_r[i] = 1'b0;

        runs[0] = '{which:0, mode:0, seed:8'hA5, npat:16,  cntw:8, exp_lat:130,  hand_cnt:0};
        runs[1] = '{which:0, mode:1, seed:8'hA5, npat:16,  cntw:8, exp_lat:130,  hand_cnt:-1};
        runs[2] = '{which:0, mode:2, seed:8'hA5, npat:16,  cntw:8, exp_lat:130,  hand_cnt:-1};
        runs[3] = '{which:0, mode:3, seed:8'hA5, npat:16,  cntw:8, exp_lat:130,  hand_cnt:-1};
        runs[4] = '{which:1, mode:2, seed:8'hA5, npat:1,   cntw:8, exp_lat:10,   hand_cnt:1};
        runs[5] = '{which:2, mode:3, seed:8'hA5, npat:255, cntw:2, exp_lat:2042, hand_cnt:3};

        // Reset state while RN is low
        #3;
        check("rst_lat_rn", 32'(if0.lat_rn), 32'd0);
        check("rst_lat_e", 32'(if0.lat_e), 32'd0);
        check("rst_lat_d", 32'(if0.lat_d), 32'd0);
        check("rst_busy", 32'(busy_w[0]), 32'd0);
        check("rst_done", 32'(done_w[0]), 32'd0);
        check("rst_pass", 32'(pass_w[0]), 32'd0);
        check("rst_fail_cnt", cnt_w[0], 32'd0);
        check("rst_ffi", ffi_w[0], 32'd0);
        @(negedge clk);
        rn = 1'b1;
        @(posedge clk);
        #1;
        check("idle_lat_rn", 32'(if0.lat_rn), 32'd1);
        check("idle_busy", 32'(busy_w[0]), 32'd0);

        for (int k = 0; k < 6; k++) begin
            if (runs[k].which == 0) mode0 = runs[k].mode;
            ref_run(runs[k].seed, runs[k].npat, runs[k].mode, cnt, first);
            cmax      = (1 << runs[k].cntw) - 1;
            exp_cnt   = (runs[k].hand_cnt >= 0) ? runs[k].hand_cnt : ((cnt > cmax) ? cmax : cnt);
            exp_first = (first < 0) ? 0 : first;
            do_run(runs[k].which, runs[k].exp_lat + 10, lat);
            check($sformatf("run%0d_done_latency", k), 32'(lat), 32'(runs[k].exp_lat));
            check($sformatf("run%0d_fail_cnt", k), cnt_w[runs[k].which], 32'(exp_cnt));
            check($sformatf("run%0d_pass", k), 32'(pass_w[runs[k].which]), 32'(exp_cnt == 0));
            check($sformatf("run%0d_busy_fin", k), 32'(busy_w[runs[k].which]), 32'd0);
`ifdef LATRNQ_BIST_FAIL_LOG_EN
            check($sformatf("run%0d_first_fail_idx", k), ffi_w[runs[k].which], 32'(exp_first));
`endif
            @(posedge clk);
            #1;
            check($sformatf("run%0d_done_one_cycle", k), 32'(done_w[runs[k].which]), 32'd0);
            check($sformatf("run%0d_pass_held", k), 32'(pass_w[runs[k].which]),
                  32'(exp_cnt == 0));
        end

        // SEED=0 (runs from 8'h01), Q=D, second START while busy must be ignored
        ref_run(8'h00, 16, 3, cnt, first);
        lat = -1;
        @(negedge clk);
        start_r[3] = 1'b1;
        @(posedge clk);
        #1;
        start_r[3] = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk);
            #1;
            start_r[3] = (c == 20);
            if (done_w[3]) begin
                lat = c;
                break;
            end
        end
        start_r[3] = 1'b0;
        check("seed0_done_latency", 32'(lat), 32'd130);
        check("seed0_fail_cnt", cnt_w[3], 32'(cnt));
        check("seed0_pass", 32'(pass_w[3]), 32'(cnt == 0));
`ifdef LATRNQ_BIST_FAIL_LOG_EN
        check("seed0_first_fail_idx", ffi_w[3], 32'((first < 0) ? 0 : first));
`endif

        // START during FIN ignored; START held into IDLE starts the next run
        mode0 = 0;
        do_run(0, 150, lat);
        check("fin_run_latency", 32'(lat), 32'd130);
        start_r[0] = 1'b1;
        @(posedge clk);
        #1;
        check("fin_start_ignored", 32'(busy_w[0]), 32'd0);
        @(posedge clk);
        #1;
        start_r[0] = 1'b0;
        check("idle_start_taken", 32'(busy_w[0]), 32'd1);
        lat = -1;
        for (int c = 1; c <= 150; c++) begin
            @(posedge clk);
            #1;
            if (done_w[0]) begin
                lat = c;
                break;
            end
        end
        check("restart_latency", 32'(lat), 32'd130);
        check("restart_pass", 32'(pass_w[0]), 32'd1);

        // RN asserted mid-run: immediate reset values, no DONE afterwards
        @(negedge clk);
        start_r[0] = 1'b1;
        @(posedge clk);
        #1;
        start_r[0] = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        rn = 1'b0;
        #1;
        check("midrst_lat_rn", 32'(if0.lat_rn), 32'd0);
        check("midrst_lat_e", 32'(if0.lat_e), 32'd0);
        check("midrst_busy", 32'(busy_w[0]), 32'd0);
        check("midrst_done", 32'(done_w[0]), 32'd0);
        repeat (3) @(negedge clk);
        rn = 1'b1;
        done_seen = 0;
        for (int c = 0; c < 150; c++) begin
            @(posedge clk);
            #1;
            if (done_w[0]) done_seen++;
        end
        check("midrst_no_done", 32'(done_seen), 32'd0);
        check("midrst_idle_lat_rn", 32'(if0.lat_rn), 32'd1);
        do_run(0, 150, lat);
        check("post_rst_latency", 32'(lat), 32'd130);
        check("post_rst_pass", 32'(pass_w[0]), 32'd1);
        check("post_rst_fail_cnt", cnt_w[0], 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
